seq_div_8: RTL
==============

SEQ_DIV_8 -- requirements
Module: seq_div_8

Interface
REQ-001 Parameters: none; operand widths fixed at 16-bit dividend, 8-bit divisor.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; samples dividend and divisor when accepted.
REQ-005 dividend  input  16  unsigned dividend (the 16-bit product width of the team's 8x8 multiplier).
REQ-006 divisor  input  8  unsigned divisor.
REQ-007 busy  output  1  high while iterating (RUN state).
REQ-008 done  output  1  one-cycle pulse: results valid.
REQ-009 quotient  output  16  unsigned quotient.
REQ-010 remainder  output  8  unsigned remainder.
REQ-011 div_by_zero  output  1  present only with DIV_BY_ZERO_EN; see Configuration.

Function
REQ-012 Radix-2 restoring division, one quotient bit per cycle, MSB first; internal 9-bit partial remainder, 16-bit shift register, 4-bit iteration counter.
REQ-013 States: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at edge k -> latch operands, clear partial remainder, counter=15, enter RUN.
REQ-015 RUN, each edge: r = {r[7:0], next dividend bit}; if r >= divisor then r -= divisor and quotient bit = 1, else quotient bit = 0; counter decrements.
REQ-016 RUN with counter=0: the 16th iteration completes at edge k+16, state -> DONE.
REQ-017 DONE: done=1 for exactly one cycle (k+16 to k+17); next state IDLE, or RUN if start=1 at that edge.
REQ-018 Latency: start accepted at edge k -> done high after edge k+16; busy high after edges k+1..k+16, i.e. exactly 16 cycles.
REQ-019 quotient/remainder update only upon entering DONE; held stable until the next DONE; never show intermediate values.
REQ-020 Result satisfies dividend = quotient*divisor + remainder, remainder < divisor, for every divisor != 0.
REQ-021 start while in RUN is ignored; the in-flight operation and its operands are unaffected.
REQ-022 Operand inputs may change freely after acceptance; only the values latched at acceptance are used.
REQ-023 divisor=0 without the macro: normal 16-cycle run yields quotient 16'hFFFF, remainder dividend[7:0].

Reset
REQ-024 rst_n low forces IDLE immediately, regardless of clock: busy=0, done=0, quotient=16'h0000, remainder=8'h00, counter=0, div_by_zero=0.
REQ-025 Reset during RUN aborts the operation; no done pulse follows; the first start after rst_n rises is accepted normally.

Configuration
REQ-026 Macro DIV_BY_ZERO_EN defined: port div_by_zero exists; divisor=0 at acceptance skips RUN and goes directly to DONE at edge k+1 with quotient=16'hFFFF, remainder=dividend[7:0], div_by_zero=1; busy stays 0.
REQ-027 With DIV_BY_ZERO_EN, div_by_zero updates together with quotient/remainder, is held until the next DONE, and is cleared by any nonzero-divisor result.
REQ-028 Macro undefined: no div_by_zero port; divisor=0 follows REQ-023.

Verification
REQ-029 dividend=16'h03E8, divisor=8'h07, start pulse -> done after 16 busy cycles, quotient=16'h008E, remainder=8'h06.
REQ-030 dividend=16'hFFFF, divisor=8'hFF -> quotient=16'h0101, remainder=8'h00; dividend=16'h0064, divisor=8'hC8 -> quotient=16'h0000, remainder=8'h64.
REQ-031 start with 16'h1234/8'h05, then start with 16'h0010/8'h02 at RUN cycle 5 -> only one done; quotient=16'h03A4, remainder=8'h00.
REQ-032 rst_n low at RUN cycle 8 -> outputs zero at once, no done; subsequent 16'h0009/8'h02 -> quotient=16'h0004, remainder=8'h01.
REQ-033 dividend=16'h1234, divisor=8'h00 -> quotient=16'hFFFF, remainder=8'h34; done 1 cycle after acceptance with div_by_zero=1 (macro on), 16 cycles after (macro off).
REQ-034 Random self-check: 10000 operand pairs, back-to-back starts issued in DONE -> every result satisfies REQ-020; no idle cycles lost between operations.

Source files
------------

// File: rtl/seq_div_8.sv
// seq_div_8: 16-bit by 8-bit unsigned sequential divider.
// Radix-2 restoring algorithm, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request pulse, accepted in IDLE or DONE
//   dividend[15:0]    unsigned dividend, latched on acceptance
//   divisor[7:0]      unsigned divisor, latched on acceptance
//   busy              high while iterating
//   done              one-cycle pulse, results valid
//   quotient[15:0]    result, updated only on entering DONE
//   remainder[7:0]    result, updated only on entering DONE
//   div_by_zero       only with `DIV_BY_ZERO_EN
// Optional feature macro: DIV_BY_ZERO_EN. When defined, a zero divisor
// bypasses the iteration and completes one cycle after acceptance.
module seq_div_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder
`ifdef DIV_BY_ZERO_EN
    ,
    output logic        div_by_zero
`endif
);

    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [VW-1:0] rem_q, rem_d;       // partial remainder (always < divisor between steps)
    logic [DW-1:0] shreg_q, shreg_d;   // dividend bits shift out, quotient bits shift in
    logic [VW-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] remo_q, remo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef DIV_BY_ZERO_EN
    logic          dbz_q, dbz_d;
`endif

    logic [VW:0]   trial;              // 9-bit shifted partial remainder
    logic [VW-1:0] diff;
    logic          take;
    logic          accept;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_BY_ZERO_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_BY_ZERO_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    // Next-state, iteration step and result capture
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        shreg_d = shreg_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
`ifdef DIV_BY_ZERO_EN
        dbz_d   = dbz_q;
`endif
        trial  = {rem_q, shreg_q[DW-1]};
        take   = (trial >= {1'b0, dvsr_q});
        // Low 8 bits suffice: when take is set the true difference is < divisor.
        diff   = trial[VW-1:0] - dvsr_q;
        accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE: begin
            end
            S_RUN: begin
                rem_d   = take ? diff : trial[VW-1:0];
                shreg_d = {shreg_q[DW-2:0], take};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    quot_d  = {shreg_q[DW-2:0], take};
                    remo_d  = rem_d;
`ifdef DIV_BY_ZERO_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Acceptance overrides the DONE->IDLE return so back-to-back starts lose no cycle.
        if (accept) begin
            dvsr_d  = divisor;
            shreg_d = dividend;
            rem_d   = '0;
            cnt_d   = CW'(DW - 1);
            state_d = S_RUN;
`ifdef DIV_BY_ZERO_EN
            if (divisor == '0) begin
                state_d = S_DONE;
                cnt_d   = '0;
                quot_d  = '1;
                remo_d  = dividend[VW-1:0];
                dbz_d   = 1'b1;
            end
`endif
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
`ifdef DIV_BY_ZERO_EN
    assign div_by_zero = dbz_q;
`endif

endmodule
